draw_cel_seq: RTL and testbench
===============================

DRAW_CEL_SEQ -- requirements
Module: draw_cel_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning width of the pass-through row-count and coordinate words.
REQ-002 SHALL have parameter MAX_ROWS, default 1024, meaning the largest accepted row count; larger requests are clamped to it.
REQ-003 SHALL have port aclk, input, 1, the single clock, with all state on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to draw one cel, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, level request to stop after the row in flight.
REQ-007 SHALL have ports x0_1616 and y0_1616, input, 32 each, start position in signed 16.16 fixed point.
REQ-008 SHALL have ports vdx_1616 and vdy_1616, input, 32 each, per-row step in signed 16.16.
REQ-009 SHALL have port row_len, input, 32, pixels per row, passed to the row drawer unchanged.
REQ-010 SHALL have port row_num, input, 16, number of rows to draw.
REQ-011 SHALL have port row_req, output, 1, request to the row drawer.
REQ-012 SHALL have ports row_xcur and row_ycur, output, 32 each, signed integer row origin.
REQ-013 SHALL have port row_cnt, output, 32, pixel count for the current row.
REQ-014 SHALL have port row_busy, input, 1, busy flag from the row drawer.
REQ-015 SHALL have port busy, output, 1, asserted in every state other than IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when the cel completes or is aborted.
REQ-017 SHALL have port rows_done, output, 16, count of rows completed in the current or last cel.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, STEP and FINISH.
REQ-019 IDLE with start=1 SHALL latch all inputs, set the accumulators x=x0, y=y0, clear rows_done, and go to ISSUE the next cycle.
REQ-020 IDLE with start=1 and row_num=0 SHALL go directly to FINISH without asserting row_req.
REQ-021 ISSUE SHALL drive row_req=1, row_xcur=x>>>16, row_ycur=y>>>16 (arithmetic shift) and row_cnt=row_len, then go to WAIT_ACK.
REQ-022 WAIT_ACK SHALL hold row_req=1 and all row_* values stable until row_busy=1 is sampled, then deassert row_req on the next cycle and go to WAIT_DONE.
REQ-023 WAIT_DONE SHALL wait for row_busy=0, then increment rows_done and go to STEP.
REQ-024 STEP SHALL compute x+=vdx_1616 and y+=vdy_1616 with 32-bit two's-complement wrap, then go to FINISH if rows_done equals the latched row count or abort=1, otherwise to ISSUE.
REQ-025 FINISH SHALL pulse done=1 for exactly one cycle, then go to IDLE.
REQ-026 Latency from row_busy falling to the next row_req rising SHALL be exactly 2 cycles (STEP, then ISSUE).
REQ-027 abort SHALL never drop row_req before the acknowledge, and SHALL never cut a row short; it takes effect only in STEP.
REQ-028 start outside IDLE SHALL be ignored, and input changes after the latch SHALL not affect the cel in progress.
REQ-029 A row_num greater than MAX_ROWS SHALL be clamped to MAX_ROWS.

Reset
REQ-030 aresetn=0 SHALL force IDLE immediately, with row_req=0, busy=0, done=0, rows_done=0, row_xcur=0, row_ycur=0, row_cnt=0 and both accumulators=0.
REQ-031 A reset in the middle of a cel SHALL abandon it with no done pulse; the row drawer is reset by the same aresetn.

Structure
REQ-032 The state enum, the signed 16.16 typedef fx1616_t and the helper constant FX_FRAC=16 SHALL live in the shared draw package alongside int32_t.
REQ-033 The x/y accumulator pair with its integer extraction SHALL be one sub-module, draw_fx_stepper (ports load, step, x0, y0, dx, dy, xi, yi).

Verification
REQ-034 The bench SHALL cover: x0=10<<16, y0=10<<16, vdy=1<<16, vdx=0, row_len=10, row_num=3 -> three row_req with ycur=10,11,12 and xcur=10, then done, rows_done=3.
REQ-035 The bench SHALL cover: vdx=0x8000 (0.5), row_num=4, x0=0 -> xcur=0,0,1,1.
REQ-036 The bench SHALL cover: row_num=0 -> done 2 cycles after start, row_req never asserted.
REQ-037 The bench SHALL cover: abort raised during row 2 of 5 -> row 2 completes, done pulses, rows_done=2, no third row_req.
REQ-038 The bench SHALL cover: y0=0x7FFF0000, vdy=1<<16, row_num=2 -> ycur=32767, then -32768 (wrap).
REQ-039 The bench SHALL cover: aresetn pulsed low in WAIT_DONE -> row_req, busy and rows_done are 0 immediately, no done pulse, and the next start runs normally.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types for the cel drawing sequencer.
// Fixed-point formats, state encoding and small helpers.
package draw_pkg;

    typedef logic signed [31:0] int32_t;
    typedef logic signed [31:0] fx1616_t;

    localparam int FX_FRAC = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        STEP,
        FINISH
    } cel_state_t;

    // Integer part of a signed 16.16 value, rounding toward -inf.
    function automatic int32_t fx_int(input fx1616_t v);
        return v >>> FX_FRAC;
    endfunction

endpackage

// File: rtl/draw_fx_stepper.sv
// Signed 16.16 x/y accumulator pair for row origins.
// Loads a start point, then adds a fixed step per row.
module draw_fx_stepper
    import draw_pkg::*;
(
    input  logic    aclk,
    input  logic    aresetn,
    input  logic    load,
    input  logic    step,
    input  fx1616_t x0,
    input  fx1616_t y0,
    input  fx1616_t dx,
    input  fx1616_t dy,
    output int32_t  xi,
    output int32_t  yi
);

    fx1616_t x;
    fx1616_t y;

    // Accumulators: load wins over step; adds wrap in 32 bits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= x0;
            y <= y0;
        end else if (step) begin
            x <= x + dx;
            y <= y + dy;
        end
    end

    assign xi = fx_int(x);
    assign yi = fx_int(y);

endmodule

// File: rtl/draw_cel_seq.sv
// Cel sequencer: walks a cel row by row, handing each
// row origin and length to a row drawer via req/busy.
module draw_cel_seq
    import draw_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_ROWS   = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  fx1616_t               x0_1616,
    input  fx1616_t               y0_1616,
    input  fx1616_t               vdx_1616,
    input  fx1616_t               vdy_1616,
    input  logic [ADDR_WIDTH-1:0] row_len,
    input  logic [15:0]           row_num,
    output logic                  row_req,
    output logic [ADDR_WIDTH-1:0] row_xcur,
    output logic [ADDR_WIDTH-1:0] row_ycur,
    output logic [ADDR_WIDTH-1:0] row_cnt,
    input  logic                  row_busy,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           rows_done
);

    localparam logic [15:0] MAX_N = 16'(MAX_ROWS);

    cel_state_t state;
    cel_state_t nxt;

    logic [15:0]           num_q;
    logic [15:0]           num_clamp;
    fx1616_t               vdx_q;
    fx1616_t               vdy_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic                  load;
    logic                  step_en;
    logic                  row_fin;
    int32_t                xi;
    int32_t                yi;

    assign num_clamp = (row_num > MAX_N) ? MAX_N : row_num;
    assign row_fin   = (state == WAIT_DONE) && !row_busy;

    draw_fx_stepper u_step (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (load),
        .step    (step_en),
        .x0      (x0_1616),
        .y0      (y0_1616),
        .dx      (vdx_q),
        .dy      (vdy_q),
        .xi      (xi),
        .yi      (yi)
    );

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= nxt;
    end

    // Next state and per-state strobes.
    always_comb begin
        nxt     = state;
        load    = 1'b0;
        step_en = 1'b0;
        row_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    nxt  = (num_clamp == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                row_req = 1'b1;
                nxt     = WAIT_ACK;
            end
            WAIT_ACK: begin
                row_req = 1'b1;
                if (row_busy) nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!row_busy) nxt = STEP;
            end
            STEP: begin
                step_en = 1'b1;
                if (rows_done == num_q || abort) nxt = FINISH;
                else                             nxt = ISSUE;
            end
            FINISH: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // Latched cel parameters and completed-row counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            num_q     <= '0;
            vdx_q     <= '0;
            vdy_q     <= '0;
            len_q     <= '0;
            rows_done <= '0;
        end else if (load) begin
            num_q     <= num_clamp;
            vdx_q     <= vdx_1616;
            vdy_q     <= vdy_1616;
            len_q     <= row_len;
            rows_done <= '0;
        end else if (row_fin) begin
            rows_done <= rows_done + 16'd1;
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);
    assign row_cnt  = len_q;
    assign row_xcur = ADDR_WIDTH'(xi);
    assign row_ycur = ADDR_WIDTH'(yi);

endmodule

// File: tb/tb_draw_cel_seq.sv
// Scoreboard bench for draw_cel_seq with a modelled
// row drawer and a reference built from x0 + i*dx.
module tb_draw_cel_seq;

    localparam int MAXR = 16;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic               start;
    logic               abort;
    logic signed [31:0] x0_1616;
    logic signed [31:0] y0_1616;
    logic signed [31:0] vdx_1616;
    logic signed [31:0] vdy_1616;
    logic [31:0]        row_len;
    logic [15:0]        row_num;
    logic               row_req;
    logic [31:0]        row_xcur;
    logic [31:0]        row_ycur;
    logic [31:0]        row_cnt;
    logic               row_busy;
    logic               busy;
    logic               done;
    logic [15:0]        rows_done;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] c;
    } row_t;

    row_t exp_rows[$];
    int   exp_done[$];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int rows_seen  = 0;
    int start_cyc  = 0;
    bit zero_case  = 0;

    draw_cel_seq #(
        .ADDR_WIDTH (32),
        .MAX_ROWS   (MAXR)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .abort     (abort),
        .x0_1616   (x0_1616),
        .y0_1616   (y0_1616),
        .vdx_1616  (vdx_1616),
        .vdy_1616  (vdy_1616),
        .row_len   (row_len),
        .row_num   (row_num),
        .row_req   (row_req),
        .row_xcur  (row_xcur),
        .row_ycur  (row_ycur),
        .row_cnt   (row_cnt),
        .row_busy  (row_busy),
        .busy      (busy),
        .done      (done),
        .rows_done (rows_done)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s", nm);
    endtask

    // Row drawer: acks a request after 0-2 cycles, busy 2-5 cycles.
    initial begin
        int d;
        int h;
        row_busy = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn && row_req) begin
                d = $urandom_range(0, 2);
                for (int i = 0; i < d && aresetn; i++) @(negedge aclk);
                if (aresetn) begin
                    row_busy = 1'b1;
                    h = $urandom_range(2, 5);
                    for (int i = 0; i < h && aresetn; i++) @(negedge aclk);
                    row_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: samples just after each rising edge.
    initial begin
        bit   prev_req;
        bit   prev_busy;
        bit   prev_done;
        bit   have_fall;
        int   fall_cyc;
        row_t cur;
        row_t e;
        prev_req  = 0;
        prev_busy = 0;
        prev_done = 0;
        have_fall = 0;
        fall_cyc  = 0;
        forever begin
            @(posedge aclk);
            #1;
            cyc++;
            if (!aresetn) begin
                prev_req  = 0;
                prev_busy = 0;
                prev_done = 0;
                have_fall = 0;
                continue;
            end
            if (prev_busy && !row_busy) begin
                have_fall = 1;
                fall_cyc  = cyc;
            end
            if (row_req && !prev_req) begin
                rows_seen++;
                // busy seen low at one edge: STEP, then ISSUE next edge
                if (have_fall)
                    chk("busy_to_req_lat", 32'(cyc - fall_cyc), 32'd1);
                have_fall = 0;
                cur.x = row_xcur;
                cur.y = row_ycur;
                cur.c = row_cnt;
                if (exp_rows.size() == 0) begin
                    fail("unexpected_row_req");
                end else begin
                    e = exp_rows.pop_front();
                    chk("row_xcur", row_xcur, e.x);
                    chk("row_ycur", row_ycur, e.y);
                    chk("row_cnt", row_cnt, e.c);
                end
            end else if (row_req) begin
                chk("hold_xcur", row_xcur, cur.x);
                chk("hold_ycur", row_ycur, cur.y);
                chk("hold_cnt", row_cnt, cur.c);
            end
            if (done) begin
                if (prev_done) fail("done_wider_than_1");
                if (exp_done.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    chk("rows_done", 32'(rows_done),
                        32'(exp_done.pop_front()));
                    if (zero_case)
                        chk("zero_done_lat", 32'(cyc - start_cyc), 32'd1);
                end
                have_fall = 0;
            end
            prev_req  = row_req;
            prev_busy = row_busy;
            prev_done = done;
        end
    end

    task automatic scramble();
        x0_1616  = $urandom;
        y0_1616  = $urandom;
        vdx_1616 = $urandom;
        vdy_1616 = $urandom;
        row_len  = $urandom;
        row_num  = 16'($urandom);
    endtask

    // Reference: row i origin is floor((p0 + i*d) / 65536), wrapped.
    task automatic push_cel(input logic signed [31:0] x0,
                            input logic signed [31:0] y0,
                            input logic signed [31:0] dx,
                            input logic signed [31:0] dy,
                            input logic [31:0] len, input int rows);
        logic signed [31:0] xv;
        logic signed [31:0] yv;
        row_t r;
        for (int i = 0; i < rows; i++) begin
            xv  = x0 + dx * i;
            yv  = y0 + dy * i;
            r.x = xv >>> 16;
            r.y = yv >>> 16;
            r.c = len;
            exp_rows.push_back(r);
        end
        exp_done.push_back(rows);
    endtask

    task automatic run_cel(input logic signed [31:0] x0,
                           input logic signed [31:0] y0,
                           input logic signed [31:0] dx,
                           input logic signed [31:0] dy,
                           input logic [31:0] len, input logic [15:0] n,
                           input int abort_at);
        int nn;
        int rows;
        nn   = (int'(n) > MAXR) ? MAXR : int'(n);
        rows = (abort_at > 0 && abort_at < nn) ? abort_at : nn;
        push_cel(x0, y0, dx, dy, len, rows);
        @(negedge aclk);
        x0_1616   = x0;
        y0_1616   = y0;
        vdx_1616  = dx;
        vdy_1616  = dy;
        row_len   = len;
        row_num   = n;
        rows_seen = 0;
        zero_case = (nn == 0);
        start_cyc = cyc;
        start     = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            if (exp_done.size() == 0) break;
            @(negedge aclk);
            abort = (abort_at > 0 && rows_seen >= abort_at);
            start = busy && ($urandom_range(0, 7) == 0);
            scramble();
        end
        start = 1'b0;
        abort = 1'b0;
        if (exp_done.size() != 0) begin
            fail("cel_timeout");
            exp_done.delete();
        end
        chk("rows_left", 32'(exp_rows.size()), 32'd0);
        exp_rows.delete();
        zero_case = 0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic reset_mid_cel();
        bit hit;
        push_cel(32'sd0, 32'sd0, 32'sh10000, 32'sh10000, 32'd8, 5);
        @(negedge aclk);
        x0_1616   = 0;
        y0_1616   = 0;
        vdx_1616  = 32'sh10000;
        vdy_1616  = 32'sh10000;
        row_len   = 8;
        row_num   = 5;
        rows_seen = 0;
        start     = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        hit   = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge aclk);
            #2;
            if (rows_seen == 2 && row_busy && !row_req) begin
                hit = 1;
                break;
            end
        end
        if (!hit) fail("reach_wait_done");
        aresetn = 1'b0;
        #1;
        chk("rst_row_req", 32'(row_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rows_done", 32'(rows_done), 32'd0);
        chk("rst_xcur", row_xcur, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        exp_rows.delete();
        exp_done.delete();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (6) @(negedge aclk);
    endtask

    initial begin
        aresetn = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        x0_1616  = 0;
        y0_1616  = 0;
        vdx_1616 = 0;
        vdy_1616 = 0;
        row_len  = 0;
        row_num  = 0;
        repeat (3) @(negedge aclk);
        chk("init_row_req", 32'(row_req), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_rows_done", 32'(rows_done), 32'd0);
        chk("init_xcur", row_xcur, 32'd0);
        chk("init_ycur", row_ycur, 32'd0);
        chk("init_cnt", row_cnt, 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        run_cel(32'sd10 <<< 16, 32'sd10 <<< 16, 32'sd0, 32'sh10000,
                32'd10, 16'd3, 0);
        run_cel(32'sd0, 32'sh30000, 32'sh8000, 32'sd0, 32'd7, 16'd4, 0);
        run_cel(32'sd5, 32'sd5, 32'sd1, 32'sd1, 32'd3, 16'd0, 0);
        run_cel(32'sh20000, 32'sd0, 32'sh10000, 32'sh18000,
                32'd12, 16'd5, 2);
        run_cel(32'sd0, 32'sh7FFF0000, 32'sd0, 32'sh10000,
                32'd4, 16'd2, 0);
        run_cel(-32'sh18000, -32'sh1, 32'sh4000, -32'sh8000,
                32'd9, 16'd20, 0);
        reset_mid_cel();
        run_cel(32'sd10 <<< 16, 32'sd10 <<< 16, 32'sd0, 32'sh10000,
                32'd10, 16'd3, 0);

        for (int t = 0; t < 25; t++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            run_cel($urandom, $urandom, $urandom, $urandom, $urandom,
                    16'($urandom_range(0, 20)), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
